uart_rx: RTL and testbench

//   8N1 UART receiver: the receive-side counterpart of the uart transmitter in the
//   clk100 domain. Deserialises rx_pin into bytes and holds each byte in a register

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver in the clk100 domain.
// Deserialises rx_pin into bytes. Each byte is held in rx_byte/rx_valid until
// the consumer acknowledges it with rx_ack. Receiving never stalls on the
// consumer: a byte that completes while the previous one is still unacknowledged
// is dropped, and the sticky rx_overrun flag is set.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle, waiting for a 1->0 edge on the synchronised input
// START | timing to the middle of the start bit to confirm it is real
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; a high stop delivers, a low one flags an error
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             deliver, deliver_nxt;
    logic             frame_err_nxt;

    logic rx_meta;
    logic rx_s;
    logic rx_s_d;
    logic fall;

    // Two-flop synchroniser plus one delay stage for edge detection; all reset
    // to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall    = rx_s_d & ~rx_s;
    assign rx_busy = (state != IDLE);

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            deliver      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            shift        <= shift_nxt;
            deliver      <= deliver_nxt;
            rx_frame_err <= frame_err_nxt;
        end
    end

    // Next-state logic: sample at mid-start, then at each following mid-bit.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        shift_nxt     = shift;
        deliver_nxt   = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                    end else begin
                        // Line is high again at mid-start: a glitch, not a frame.
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    // Returning to IDLE at mid-stop lets a start bit that
                    // directly follows the stop bit be caught by its edge.
                    state_nxt = IDLE;
                    if (rx_s) begin
                        deliver_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output holding register: load on delivery, drop and flag overrun when the
    // previous byte is still unacknowledged, clear on acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (deliver) begin
            if (!rx_valid) begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                // Consumer frees the slot in the same cycle the new byte lands.
                rx_byte    <= shift;
                rx_overrun <= 1'b0;
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLKS_PER_BIT=16 and a 10 ns clock.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int      CPB    = 16;
    localparam realtime CYC    = 10.0;
    localparam realtime BIT_NS = CPB * CYC;

    logic       clk;
    logic       rst;
    logic       rx_pin;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_chk = 0;
    int n_bad = 0;

    logic       auto_ack = 1'b0;
    logic       ack_once = 1'b0;
    int         n_ferr   = 0;
    logic       ovr_seen = 1'b0;
    logic       valid_prev = 1'b0;
    time        t_start  = 0;
    time        t_valid  = 0;
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pin       (rx_pin),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #(CYC / 2) clk = ~clk;

    // Consumer model: observes flags on the falling edge and drives one-cycle acks.
    initial rx_ack = 1'b0;
    always @(negedge clk) begin
        if (rx_frame_err) n_ferr++;
        if (rx_overrun) ovr_seen = 1'b1;
        if (rx_valid && !valid_prev) t_valid = $time;
        valid_prev = rx_valid;
        if (rx_ack) begin
            rx_ack = 1'b0;
        end else if (rx_valid && (auto_ack || ack_once)) begin
            got_q.push_back(rx_byte);
            rx_ack   = 1'b1;
            ack_once = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame. align=1 starts on a falling clock edge; align=0 starts right
    // where the previous frame's stop bit ended (true back-to-back).
    task automatic send_byte(input logic [7:0] b, input realtime bit_ns,
                             input logic stop_bit, input logic align);
        if (align) @(negedge clk);
        t_start = $time;
        rx_pin  = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            #(bit_ns);
        end
        rx_pin = stop_bit;
        #(bit_ns);
        rx_pin = 1'b1;
    endtask

    task automatic ack_and_check(input string tag);
        ack_once = 1'b1;
        idle(2);
        chk(tag, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        rx_pin = 1'b1;
        rst    = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);

        // Reset state
        chk("rst_valid",  {31'd0, rx_valid},     32'd0);
        chk("rst_byte",   {24'd0, rx_byte},      32'd0);
        chk("rst_busy",   {31'd0, rx_busy},      32'd0);
        chk("rst_ferr",   {31'd0, rx_frame_err}, 32'd0);
        chk("rst_ovr",    {31'd0, rx_overrun},   32'd0);

        // 1: single byte, latency 2+8+144 = 154 +/-2 cycles
        send_byte(8'hA5, BIT_NS, 1'b1, 1'b1);
        idle(2);
        lat = int'((t_valid - t_start - 5) / 10);
        $display("info: latency %0d cycles", lat);
        chk("t1_latency_window", {31'd0, (lat >= 152 && lat <= 156)}, 32'd1);
        chk("t1_byte",  {24'd0, rx_byte},  32'hA5);
        chk("t1_valid", {31'd0, rx_valid}, 32'd1);
        chk("t1_ferr_count", n_ferr, 0);
        chk("t1_ovr", {31'd0, ovr_seen}, 32'd0);
        ack_and_check("t1_ack_clears_valid");

        // 2: back-to-back with auto-ack
        got_q.delete();
        auto_ack = 1'b1;
        send_byte(8'h00, BIT_NS, 1'b1, 1'b1);
        send_byte(8'hFF, BIT_NS, 1'b1, 1'b0);
        send_byte(8'h55, BIT_NS, 1'b1, 1'b0);
        idle(10);
        auto_ack = 1'b0;
        chk("t2_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t2_b0", {24'd0, got_q[0]}, 32'h00);
            chk("t2_b1", {24'd0, got_q[1]}, 32'hFF);
            chk("t2_b2", {24'd0, got_q[2]}, 32'h55);
        end
        chk("t2_ovr", {31'd0, ovr_seen}, 32'd0);
        chk("t2_valid", {31'd0, rx_valid}, 32'd0);

        // 3: overrun, first byte kept
        send_byte(8'h3C, BIT_NS, 1'b1, 1'b1);
        send_byte(8'hC3, BIT_NS, 1'b1, 1'b0);
        idle(5);
        chk("t3_byte_kept", {24'd0, rx_byte},    32'h3C);
        chk("t3_valid",     {31'd0, rx_valid},   32'd1);
        chk("t3_overrun",   {31'd0, rx_overrun}, 32'd1);
        ack_and_check("t3_ack_clears_valid");
        chk("t3_ack_clears_ovr", {31'd0, rx_overrun}, 32'd0);
        ovr_seen = 1'b0;

        // 4: stop bit low -> one frame-error pulse, no byte
        n_ferr = 0;
        send_byte(8'h5A, BIT_NS, 1'b0, 1'b1);
        idle(20);
        chk("t4_ferr_once", n_ferr, 1);
        chk("t4_no_valid", {31'd0, rx_valid}, 32'd0);
        send_byte(8'h81, BIT_NS, 1'b1, 1'b1);
        idle(2);
        chk("t4_byte", {24'd0, rx_byte},  32'h81);
        chk("t4_valid", {31'd0, rx_valid}, 32'd1);
        ack_and_check("t4_ack");

        // 5: 4-cycle glitch aborts in START
        n_ferr = 0;
        @(negedge clk);
        rx_pin = 1'b0;
        idle(4);
        rx_pin = 1'b1;
        idle(30);
        chk("t5_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("t5_no_ferr",  n_ferr, 0);
        chk("t5_idle",     {31'd0, rx_busy}, 32'd0);
        send_byte(8'h12, BIT_NS, 1'b1, 1'b1);
        idle(2);
        chk("t5_byte", {24'd0, rx_byte}, 32'h12);
        ack_and_check("t5_ack");

        // 6: reset during data bit 3
        @(negedge clk);
        rx_pin = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx_pin = 1'b1;
            #(BIT_NS);
        end
        rx_pin = 1'b0;
        #(BIT_NS / 2);
        chk("t6_busy_mid_frame", {31'd0, rx_busy}, 32'd1);
        rst    = 1'b1;
        rx_pin = 1'b1;
        #2;
        chk("t6_rst_byte",  {24'd0, rx_byte},      32'd0);
        chk("t6_rst_valid", {31'd0, rx_valid},     32'd0);
        chk("t6_rst_busy",  {31'd0, rx_busy},      32'd0);
        chk("t6_rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
        chk("t6_rst_ovr",   {31'd0, rx_overrun},   32'd0);
        idle(3);
        rst = 1'b0;
        idle(20);
        send_byte(8'h7E, BIT_NS, 1'b1, 1'b1);
        idle(2);
        chk("t6_byte", {24'd0, rx_byte}, 32'h7E);
        ack_and_check("t6_ack");

        // 7: +/-3% baud error. Whole-cycle periods of 15/17 are a 6.25% error,
        // which walks the stop-bit sample out of the stop bit, so drive
        // fractional bit periods instead.
        send_byte(8'h96, BIT_NS * 1.03, 1'b1, 1'b1);
        idle(2);
        chk("t7_slow_byte",  {24'd0, rx_byte},  32'h96);
        chk("t7_slow_valid", {31'd0, rx_valid}, 32'd1);
        ack_and_check("t7_slow_ack");
        send_byte(8'h96, BIT_NS * 0.97, 1'b1, 1'b1);
        idle(2);
        chk("t7_fast_byte",  {24'd0, rx_byte},  32'h96);
        chk("t7_fast_valid", {31'd0, rx_valid}, 32'd1);
        ack_and_check("t7_fast_ack");
        chk("t7_no_ferr", n_ferr, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
